// File: rtl/calc_sequencer_if.sv
// Operand/result bus of the TRISC calculator sequencer.
// The front end is the master and the sequencer is the slave.
// Optional macro CALC_OVF_FLAG_EN adds the ovf result flag.
//
// Handshake: an operand moves on a rising CLK edge only when
// din_valid and din_ready are both high in that cycle. din_ready
// does not depend on din_valid. The master holds din stable
// while din_valid is high and din_ready is low.
interface calc_sequencer_if #(parameter int N = 8);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         busy;
  logic [N-1:0] result;
  logic         carry;
  logic         result_valid;
`ifdef CALC_OVF_FLAG_EN
  logic         ovf;
`endif

  modport master (
    output start, op, din, din_valid,
    input  din_ready, busy, result, carry, result_valid
`ifdef CALC_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, op, din, din_valid,
    output din_ready, busy, result, carry, result_valid
`ifdef CALC_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/calc_sequencer.sv
// Operand/result sequencer for the TRISC calculator datapath.
// Collects an opcode and then operands A and B over the bus. It executes
// the op: single-cycle ALU ops, or an N-cycle shift-add multiply. It then
// loads result/carry and pulses result_valid for one cycle.
// Optional macro CALC_OVF_FLAG_EN adds a registered signed-overflow flag.
// o_dbg_state exposes the FSM state for observation.
module calc_sequencer #(
  parameter int N = 8
) (
  input  logic                CLK,
  input  logic                CLR,
  calc_sequencer_if.slave     bus,
  output logic [2:0]          o_dbg_state
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_result;
  logic             r_carry;
  logic             r_valid;
  logic             r_ready;
  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
`ifdef CALC_OVF_FLAG_EN
  logic             r_ovf;
  logic             w_ovf;
`endif

  logic [N:0]       w_sum;
  logic [N:0]       w_diff;
  logic [N-1:0]     w_res;
  logic             w_cy;
  logic [2*N-1:0]   w_acc_next;

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle ALU result and carry for every non-multiply op
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (r_op)
      OP_ADD: begin w_res = w_sum[N-1:0];  w_cy = w_sum[N];  end
      OP_SUB: begin w_res = w_diff[N-1:0]; w_cy = w_diff[N]; end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin w_res = {r_a[N-2:0], 1'b0}; w_cy = r_a[N-1]; end
      OP_SHR: begin w_res = {1'b0, r_a[N-1:1]}; w_cy = r_a[0];   end
      default: begin w_res = '0; w_cy = 1'b0; end
    endcase
  end

`ifdef CALC_OVF_FLAG_EN
  // Two's-complement overflow for ADD, SUB and SHL1; zero otherwise
  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD: w_ovf = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      OP_SUB: w_ovf = (r_a[N-1] != r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);
      OP_SHL: w_ovf = r_a[N-1] ^ r_a[N-2];
      default: w_ovf = 1'b0;
    endcase
  end
`endif

  // Sequencer FSM: operand capture, execution and registered outputs
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`ifdef CALC_OVF_FLAG_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_GET_A;
          end
        end
        S_GET_A: begin
          if (bus.din_valid && r_ready) begin
            r_a     <= bus.din;
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (bus.din_valid && r_ready) begin
            r_b     <= bus.din;
            r_ready <= 1'b0;
            r_state <= S_EXEC;
            if (r_op == OP_MUL) begin
              r_acc    <= '0;
              r_cnt    <= CW'(N);
              r_mcand  <= {{N{1'b0}}, r_a};
              r_mplier <= bus.din;
            end
          end
        end
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            // One multiplier bit per cycle, LSB first; last step loads result
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_result <= w_acc_next[N-1:0];
              r_carry  <= |w_acc_next[2*N-1:N];
`ifdef CALC_OVF_FLAG_EN
              r_ovf    <= 1'b0;
`endif
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
          end else begin
            r_result <= w_res;
            r_carry  <= w_cy;
`ifdef CALC_OVF_FLAG_EN
            r_ovf    <= w_ovf;
`endif
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.din_ready    = r_ready;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.carry        = r_carry;
  assign bus.result_valid = r_valid;
`ifdef CALC_OVF_FLAG_EN
  assign bus.ovf          = r_ovf;
`endif
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: a table of directed ALU/MUL
// vectors plus hand-written sequences for backpressure, ignored start,
// din_valid outside GET_A/GET_B, and asynchronous reset during a multiply.
module tb_calc_sequencer;
  localparam int N = 8;
  localparam int W = N + 2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       CLR;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  calc_sequencer_if #(.N(N)) bus();

  calc_sequencer #(.N(N)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [W-1:0] exp_q[$];   // {ovf, carry, result}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         cy;
    logic         ov;
  } vec_t;

  vec_t vecs[14];

  // ---------------- driver tasks ----------------
  // Pulse start for one cycle, then scramble op to show it is latched
  task automatic do_start(input logic [2:0] op);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.op    = op;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.op    = ~op;
  endtask

  // Hold din_valid low for gap cycles, then offer d until accepted
  task automatic send(input logic [N-1:0] d, input int gap, input string name);
    int t;
    bus.din_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    bus.din       = d;
    bus.din_valid = 1'b1;
    t = 0;
    while (!bus.din_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_ready"}, {31'd0, bus.din_ready}, 32'd1);
    @(negedge CLK);
    bus.din_valid = 1'b0;
    bus.din       = N'($urandom_range(0, 255));
  endtask

  // Full operation with latency, result-hold and completion checks
  task automatic run_vec(input vec_t v, input int ga, input int gb, input string name);
    logic [N-1:0] prev_res;
    logic         prev_cy;
    logic [W-1:0] e;
    int lat;
    int exp_lat;
    exp_q.push_back({v.ov, v.cy, v.res});
    do_start(v.op);
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    send(v.a, ga, {name, "_a"});
    prev_res = bus.result;
    prev_cy  = bus.carry;
    send(v.b, gb, {name, "_b"});
    exp_lat = (v.op == OP_MUL) ? N + 1 : 2;
    lat = 1;
    while (!bus.result_valid && lat < 40) begin
      check({name, "_hold"}, {23'd0, bus.carry, bus.result}, {23'd0, prev_cy, prev_res});
      @(negedge CLK);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    if (bus.result_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_result"}, {24'd0, bus.result}, {24'd0, e[N-1:0]});
      check({name, "_carry"},  {31'd0, bus.carry},  {31'd0, e[N]});
`ifdef CALC_OVF_FLAG_EN
      check({name, "_ovf"},    {31'd0, bus.ovf},    {31'd0, e[N+1]});
`endif
    end else begin
      check({name, "_completion"}, {31'd0, bus.result_valid}, 32'd1);
    end
    @(negedge CLK);
    check({name, "_pulse_end"}, {31'd0, bus.result_valid}, 32'd0);
    check({name, "_busy_low"},  {31'd0, bus.busy},         32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int pulses;

    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[6]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{OP_SHL, 8'h81, 8'h55, 8'h02, 1'b1, 1'b1};
    vecs[8]  = '{OP_SHL, 8'h40, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{OP_SHR, 8'h81, 8'hAA, 8'h40, 1'b1, 1'b0};
    vecs[10] = '{OP_MUL, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{OP_MUL, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0};

    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    CLR           = 1'b0;

    // Reset state
    #1;
    check("rst_result",    {24'd0, bus.result},       32'd0);
    check("rst_carry",     {31'd0, bus.carry},        32'd0);
    check("rst_valid",     {31'd0, bus.result_valid}, 32'd0);
    check("rst_ready",     {31'd0, bus.din_ready},    32'd0);
    check("rst_busy",      {31'd0, bus.busy},         32'd0);
    check("rst_state",     {29'd0, dbg_state},        32'd0);
`ifdef CALC_OVF_FLAG_EN
    check("rst_ovf",       {31'd0, bus.ovf},          32'd0);
`endif
    repeat (2) @(negedge CLK);
    CLR = 1'b1;

    // din_valid while idle: no transfer, din_ready stays low
    @(negedge CLK);
    bus.din_valid = 1'b1;
    bus.din       = 8'h33;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("idle_din_ready", {31'd0, bus.din_ready}, 32'd0);
      check("idle_state",     {29'd0, dbg_state},     32'd0);
    end
    bus.din_valid = 1'b0;

    // Table of directed vectors
    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], 0, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: 3 idle cycles in GET_A, 5 in GET_B
    run_vec('{OP_XOR, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0}, 3, 5, "bp_xor");

    // start pulsed in GET_B, EXEC and DONE is ignored
    do_start(OP_ADD);
    send(8'h12, 0, "si_a");
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    @(negedge CLK);
    bus.start = 1'b0;
    check("si_state_getb", {29'd0, dbg_state}, 32'd2);
    send(8'h34, 0, "si_b");
    bus.start = 1'b1;
    @(negedge CLK);
    pulses = bus.result_valid ? 1 : 0;
    check("si_result", {23'd0, bus.carry, bus.result}, {23'd0, 1'b0, 8'h46});
    @(negedge CLK);
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.result_valid) pulses++;
      check("si_busy_low", {31'd0, bus.busy}, 32'd0);
      @(negedge CLK);
    end
    check("si_pulse_count", pulses, 1);

    // Asynchronous reset in the 4th EXEC cycle of a multiply
    exp_q.push_back({1'b0, 1'b1, 8'hFD});
    do_start(OP_MUL);
    send(8'hFF, 0, "clr_a");
    send(8'h03, 0, "clr_b");
    repeat (3) @(negedge CLK);
    #2;
    CLR = 1'b0;
    #1;
    check("clr_result", {24'd0, bus.result},       32'd0);
    check("clr_carry",  {31'd0, bus.carry},        32'd0);
    check("clr_valid",  {31'd0, bus.result_valid}, 32'd0);
    check("clr_ready",  {31'd0, bus.din_ready},    32'd0);
    check("clr_busy",   {31'd0, bus.busy},         32'd0);
    check("clr_state",  {29'd0, dbg_state},        32'd0);
    exp_q.delete();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (k == 2) CLR = 1'b1;
      if (bus.result_valid) pulses++;
    end
    check("clr_no_pulse", pulses, 0);
    run_vec('{OP_SHR, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0}, 0, 0, "post_clr_shr");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Operand/result sequencer for the 8-bit TRISC calculator datapath.
- Accepts an opcode, then two operands over a shared valid/ready operand bus.
- Latches the operands into internal operand registers (A, B) and executes the op; multiply is iterative.
- Loads the result register and signals completion.
- Sits between the front-end input logic and the display/result consumer, and owns all register load timing.

Parameters:
N, 8, datapath width of the operands, the result and the multiply iteration count

Ports:
CLK  input  1  clock, rising-edge active
CLR  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin an operation; sampled only in IDLE
op  input  3  opcode, latched with start: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 MUL
din  input  N  operand bus
din_valid  input  1  din holds a valid operand
din_ready  output  1  sequencer accepts an operand this cycle
busy  output  1  high in every state except IDLE
result  output  N  result register
carry  output  1  carry/borrow/shift-out/multiply-overflow flag, registered with result
result_valid  output  1  one-cycle completion pulse

Behaviour:
Clock and reset:
- Clock CLK, rising edge.
- Reset CLR is asynchronous and active-low.
- While CLR=0, all state is forced: state=IDLE, A=B=0, result=0, carry=0, result_valid=0, din_ready=0, busy=0, multiply counter=0, latched op=0.
- CLR asserted mid-operation aborts the operation with no completion pulse.

States: IDLE, GET_A, GET_B, EXEC, DONE.
- IDLE: if start=1, latch op and go to GET_A. Otherwise stay.
- GET_A: din_ready=1. A transfer occurs when din_valid=1 and din_ready=1; it latches A=din and moves to GET_B. With din_valid=0, stay indefinitely.
- GET_B: same rule for B. On transfer, move to EXEC. For MUL, also load the accumulator=0 and count=N.
- EXEC for non-MUL ops: exactly 1 cycle. Compute the op, load result and carry, move to DONE.
- EXEC for MUL: shift-add, one bit of B per cycle, LSB first. Stay in EXEC for exactly N cycles, then move to DONE.
- DONE: result_valid=1 for exactly this cycle, then return to IDLE.
- din_ready is 0 in every state other than GET_A and GET_B.

Carry rules:
- ADD: result=(A+B) mod 2^N; carry=bit N of the sum.
- SUB: result=(A-B) mod 2^N; carry=1 when A<B (unsigned borrow).
- AND/OR/XOR: carry=0.
- SHL1: carry=A[N-1].
- SHR1: carry=A[0], with zero fill.
- B is still collected for SHL1 and SHR1 and is ignored.
- MUL: result=low N bits of A*B; carry=1 if the high N bits are nonzero.

Register timing:
- result and carry update only on the EXEC-to-DONE transition, and hold until the next such transition.
- During a MUL, result keeps the previous value.

Latency, counted from the B-transfer edge: non-MUL ops give result_valid 2 cycles later; MUL gives it N+1 cycles later.

Boundary conditions:
- start while busy is ignored, including in the DONE cycle; no queueing.
- din_valid in IDLE, EXEC or DONE is ignored, and no transfer occurs.
- An op change after start has no effect.
- MUL with A=0 or B=0 still takes the full N cycles.

Optional Feature:
Macro: CALC_OVF_FLAG_EN
- When the macro is defined, an extra output port ovf (1 bit, registered with result, reset 0) is present.
- ovf reports two's-complement signed overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - SHL1: A[N-1]≠A[N-2].
  - All other ops: 0.
- When the macro is undefined, the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then ADD with A=0xFF, B=0x01 → result=0x00, carry=1; result_valid exactly 2 cycles after the B transfer; busy low the cycle after.
- SUB with A=0x05, B=0x07 → result=0xFE, carry=1. SUB with A=0x07, B=0x05 → result=0x02, carry=0. With CALC_OVF_FLAG_EN, ADD 0x7F+0x01 → ovf=1.
- MUL 0x0F*0x11 → result=0xFF, carry=0. MUL 0x10*0x10 → result=0x00, carry=1. result_valid 9 cycles after the B transfer; result holds its old value during EXEC.
- Operand backpressure: din_valid low for 3 cycles in GET_A and 5 cycles in GET_B → FSM waits, operands are captured correctly, and XOR 0xA5^0x5A=0xFF.
- start pulsed in GET_B, EXEC and DONE → ignored, and exactly one result_valid pulse follows. din_valid=1 in IDLE → din_ready stays 0.
- CLR driven low at cycle 4 of a MUL → all outputs 0 immediately (asynchronously) with no result_valid. After release, a new SHR1 with A=0x81 → result=0x40, carry=1.
